// File: rtl/sparse_block_pruner.sv
// Block-sparsity pruner: keeps the KEEP highest-L1 blocks of every tile row and zeroes the rest.
// Tile is buffered, scored in one cycle, then one block per row is selected per cycle.
module sparse_block_pruner #(
    parameter int DATA_WIDTH       = 8,
    parameter int DIM0             = 4,
    parameter int DIM1             = 2,
    parameter int BLOCK_NUM        = 2,
    parameter int SPARSE_BLOCK_NUM = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DIM0*DIM1-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [DIM0*DIM1-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [DIM1*BLOCK_NUM-1:0]             out_mask,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int BLOCK_SIZE  = DIM0 / BLOCK_NUM;
    localparam int KEEP        = BLOCK_NUM - SPARSE_BLOCK_NUM;
    localparam int SCORE_WIDTH = (BLOCK_SIZE > 1) ? DATA_WIDTH + $clog2(BLOCK_SIZE) : DATA_WIDTH + 1;
    localparam int CNT_WIDTH   = $clog2(KEEP + 1);
    localparam int NB          = DIM1 * BLOCK_NUM;

    generate
        if (DIM0 % BLOCK_NUM != 0) begin : g_bad_dim
            $fatal(1, "sparse_block_pruner: DIM0 must be a multiple of BLOCK_NUM");
        end
        if (SPARSE_BLOCK_NUM < 0 || SPARSE_BLOCK_NUM >= BLOCK_NUM) begin : g_bad_sparse
            $fatal(1, "sparse_block_pruner: SPARSE_BLOCK_NUM must be in [0, BLOCK_NUM)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCORE, SELECT, OUT} state_t;

    state_t                                 state, state_nxt;
    logic [DIM0*DIM1-1:0][DATA_WIDTH-1:0]   tile;
    logic [DIM0*DIM1-1:0][DATA_WIDTH-1:0]   pruned;
    logic [NB-1:0][SCORE_WIDTH-1:0]         score, score_calc;
    logic [NB-1:0]                          keep, keep_nxt;
    logic [CNT_WIDTH-1:0]                   sel_cnt;
    logic                                   sel_last;

    // Magnitude as an unsigned DATA_WIDTH value, so the most negative input maps to 2^(W-1).
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? (~x + DATA_WIDTH'(1)) : x;
    endfunction

    assign in_ready = (state == IDLE);
    assign sel_last = (sel_cnt == CNT_WIDTH'(KEEP - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SCORE;
            SCORE:   state_nxt = SELECT;
            SELECT:  if (sel_last) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        score_calc = '0;
        for (int unsigned r = 0; r < DIM1; r++)
            for (int unsigned b = 0; b < BLOCK_NUM; b++)
                for (int unsigned k = 0; k < BLOCK_SIZE; k++)
                    score_calc[r*BLOCK_NUM+b] = score_calc[r*BLOCK_NUM+b]
                        + SCORE_WIDTH'(magnitude(tile[r*DIM0 + b*BLOCK_SIZE + k]));
    end

    // Per row, pick the highest-scoring unkept block; strict '>' keeps ties on the lowest index.
    always_comb begin
        logic [SCORE_WIDTH-1:0] best;
        logic [NB-1:0]          pick;
        keep_nxt = keep;
        best     = '0;
        pick     = '0;
        for (int unsigned r = 0; r < DIM1; r++) begin
            best = '0;
            pick = '0;
            for (int unsigned b = 0; b < BLOCK_NUM; b++) begin
                if (!keep[r*BLOCK_NUM+b] && (pick == '0 || score[r*BLOCK_NUM+b] > best)) begin
                    best                = score[r*BLOCK_NUM+b];
                    pick                = '0;
                    pick[r*BLOCK_NUM+b] = 1'b1;
                end
            end
            keep_nxt = keep_nxt | pick;
        end
    end

    always_comb begin
        pruned = tile;
        for (int unsigned r = 0; r < DIM1; r++)
            for (int unsigned b = 0; b < BLOCK_NUM; b++)
                for (int unsigned k = 0; k < BLOCK_SIZE; k++)
                    if (!keep_nxt[r*BLOCK_NUM+b])
                        pruned[r*DIM0 + b*BLOCK_SIZE + k] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile      <= '0;
            score     <= '0;
            keep      <= '0;
            sel_cnt   <= '0;
            out_data  <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) tile <= in_data;
                SCORE: begin
                    score   <= score_calc;
                    keep    <= '0;
                    sel_cnt <= '0;
                end
                SELECT: begin
                    keep    <= keep_nxt;
                    sel_cnt <= sel_cnt + CNT_WIDTH'(1);
                    if (sel_last) begin
                        out_data  <= pruned;
                        out_mask  <= keep_nxt;
                        out_valid <= 1'b1;
                    end
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_block_pruner.sv
// Directed bench for sparse_block_pruner: default geometry plus an 8-wide, 4-block, keep-2 instance.
module tb_sparse_block_pruner;

    typedef int vec8_t  [8];
    typedef int vec16_t [16];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0][7:0]  a_in_data, a_out_data;
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]       a_out_mask;

    logic [15:0][7:0] b_in_data, b_out_data;
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]       b_out_mask;

    int tests = 0;
    int fails = 0;
    int lat;
    int n;

    sparse_block_pruner #(
        .DATA_WIDTH(8), .DIM0(4), .DIM1(2), .BLOCK_NUM(2), .SPARSE_BLOCK_NUM(1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_mask(a_out_mask),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    sparse_block_pruner #(
        .DATA_WIDTH(8), .DIM0(8), .DIM1(2), .BLOCK_NUM(4), .SPARSE_BLOCK_NUM(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_mask(b_out_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    function automatic logic [7:0][7:0] pack8(input vec8_t v);
        logic [7:0][7:0] p;
        for (int i = 0; i < 8; i++) p[i] = 8'(v[i]);
        return p;
    endfunction

    function automatic logic [15:0][7:0] pack16(input vec16_t v);
        logic [15:0][7:0] p;
        for (int i = 0; i < 16; i++) p[i] = 8'(v[i]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One tile through dut_a with out_ready high; latency counts the accept edge as edge 1.
    task automatic run_a(input string tag, input vec8_t v, input vec8_t e, input logic [3:0] m);
        @(negedge clk);
        a_in_data   = pack8(v);
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        chk({tag, "_in_ready"}, 128'(a_in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(3));
        chk({tag, "_data"}, 128'(a_out_data), 128'(pack8(e)));
        chk({tag, "_mask"}, 128'(a_out_mask), 128'(m));
        @(negedge clk);
        chk({tag, "_done"}, 128'({a_out_valid, a_in_ready}), 128'(2'b01));
    endtask

    initial begin
        rst         = 1'b1;
        a_in_data   = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_a_in_ready",  128'(a_in_ready),  128'(1'b1));
        chk("rst_a_out_valid", 128'(a_out_valid), 128'(1'b0));
        chk("rst_a_out_data",  128'(a_out_data),  128'(0));
        chk("rst_a_out_mask",  128'(a_out_mask),  128'(0));
        chk("rst_b_ctrl",      128'({b_out_valid, b_in_ready}), 128'(2'b01));
        chk("rst_b_out_data",  128'(b_out_data),  128'(0));
        rst = 1'b0;

        run_a("t1_basic", '{1, 1, 5, -6, -7, 0, 2, 2},   '{0, 0, 5, -6, -7, 0, 0, 0},  4'b0110);
        run_a("t2_tie",   '{2, -2, -3, 1, 0, 0, 0, 0},   '{2, -2, 0, 0, 0, 0, 0, 0},   4'b0101);
        run_a("t3_neg",   '{-128, 0, 127, 0, 0, 1, -1, -1}, '{-128, 0, 0, 0, 0, 0, -1, -1}, 4'b1001);

        // Backpressure: tile T4 held in OUT; T2 already offered and must wait for IDLE.
        @(negedge clk);
        a_in_data   = pack8('{3, 3, -4, -3, 1, 0, -5, 4});
        a_in_valid  = 1'b1;
        a_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in_data = pack8('{2, -2, -3, 1, 0, 0, 0, 0});
        n = 0;
        while (!a_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 128'(a_out_valid), 128'(1'b1));
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 128'({a_out_valid, a_in_ready, a_out_mask, a_out_data}),
                128'({1'b1, 1'b0, 4'b1010, pack8('{0, 0, -4, -3, 0, 0, -5, 4})}));
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 128'({a_out_valid, a_in_ready}), 128'(2'b01));
        n = 0;
        while (!a_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_next_lat",  128'(n), 128'(3));
        chk("bp_next_data", 128'(a_out_data), 128'(pack8('{2, -2, 0, 0, 0, 0, 0, 0})));
        chk("bp_next_mask", 128'(a_out_mask), 128'(4'b0101));
        a_in_data = pack8('{-128, 0, 127, 0, 0, 1, -1, -1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_valid && n < 20);
        chk("b2b_period", 128'(n), 128'(4));
        chk("b2b_data",   128'(a_out_data), 128'(pack8('{-128, 0, 0, 0, 0, 0, -1, -1})));
        chk("b2b_mask",   128'(a_out_mask), 128'(4'b1001));
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_done", 128'({a_out_valid, a_in_ready}), 128'(2'b01));

        // Wide instance: four blocks of two, two kept per row.
        @(negedge clk);
        b_in_data   = pack16('{9, 0, 1, 0, 8, 0, 3, 0,  0, 0, 4, -4, 1, 0, -6, 1});
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_latency", 128'(lat), 128'(4));
        chk("t5_data", 128'(b_out_data),
            128'(pack16('{9, 0, 0, 0, 8, 0, 0, 0,  0, 0, 4, -4, 0, 0, -6, 1})));
        chk("t5_mask", 128'(b_out_mask), 128'(8'hA5));
        @(negedge clk);
        chk("t5_done", 128'({b_out_valid, b_in_ready}), 128'(2'b01));

        // Reset while dut_a is in SELECT.
        @(negedge clk);
        a_in_data  = pack8('{3, 3, -4, -3, 1, 0, -5, 4});
        a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ctrl", 128'({a_out_valid, a_in_ready}), 128'(2'b01));
        chk("t6_rst_out",  128'({a_out_mask, a_out_data}), 128'(0));
        rst = 1'b0;
        run_a("t6_after_rst", '{10, -20, 0, 1, 0, 0, 0, -1}, '{10, -20, 0, 0, 0, 0, 0, -1}, 4'b1001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
